// File: rtl/tensor_pkg.sv
// Shared types for the tensor issue path: operand matrices, warp/register ids
// and the per-warp slot state.
package tensor_pkg;

   localparam int WARP_ID_W = 2;
   localparam int REG_IDX_W = 4;

   typedef logic [WARP_ID_W-1:0] warp_id_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef logic signed [3:0][3:0][15:0] mat16_t;
   typedef logic signed [3:0][3:0][31:0] mat32_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      QUEUED   = 2'd1,
      INFLIGHT = 2'd2
   } slot_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester, and a
// presented-but-unaccepted choice is held so the request stays stable.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic          valid,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] start_ptr;
   logic [IW-1:0] held_idx;
   logic          held;
   logic [IW-1:0] pick_idx;
   logic          pick_found;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = start_ptr;
      for (int k = 0; k < N; k++) begin
         if (!pick_found && req[(int'(start_ptr) + k) % N]) begin
            pick_found = 1'b1;
            pick_idx   = IW'((int'(start_ptr) + k) % N);
         end
      end
   end

   // A held requester only leaves the request set by being granted, so the hold is always valid.
   always_comb begin
      valid     = held | pick_found;
      grant_idx = held ? held_idx : pick_idx;
      grant     = '0;
      if (valid) grant[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_ptr <= '0;
         held      <= 1'b0;
         held_idx  <= '0;
      end else if (valid && advance) begin
         start_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
         held      <= 1'b0;
      end else begin
         held      <= valid;
         held_idx  <= grant_idx;
      end
   end

endmodule

// File: rtl/tensor_issue_queue.sv
// Core-side tensor issuer: one operand slot per warp, round-robin request to the
// controller, destination scoreboard and registered writeback to the register file.
module tensor_issue_queue
   import tensor_pkg::*;
#(
   parameter int NUM_WARPS = 4,
   parameter int NUM_REGS  = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          issue_valid,
   input  warp_id_t                      issue_warp_id,
   input  reg_idx_t                      issue_dest_reg,
   input  mat16_t                        issue_src_a,
   input  mat16_t                        issue_src_b,
   input  mat32_t                        issue_src_c,
   output logic                          issue_ready,
   output logic                          req_valid,
   output warp_id_t                      req_warp_id,
   output reg_idx_t                      req_dest_reg,
   output mat16_t                        req_src_a,
   output mat16_t                        req_src_b,
   output mat32_t                        req_src_c,
   input  logic                          req_ready,
   input  logic                          wb_valid,
   input  warp_id_t                      wb_warp_id,
   input  reg_idx_t                      wb_reg_idx,
   input  mat32_t                        wb_data,
   output logic                          rf_we,
   output warp_id_t                      rf_warp_id,
   output reg_idx_t                      rf_reg_idx,
   output mat32_t                        rf_data,
   output logic [NUM_WARPS-1:0]          warp_wake,
   output logic [NUM_WARPS*NUM_REGS-1:0] reg_pending,
   output logic                          err_spurious
);

   slot_state_t slot_state [NUM_WARPS];
   reg_idx_t    slot_dest  [NUM_WARPS];
   mat16_t      slot_a     [NUM_WARPS];
   mat16_t      slot_b     [NUM_WARPS];
   mat32_t      slot_c     [NUM_WARPS];

   logic [NUM_WARPS-1:0] queued_vec;
   logic [NUM_WARPS-1:0] arb_grant;
   warp_id_t             arb_idx;
   logic                 arb_valid;
   logic                 accept;
   logic                 grant_fire;
   logic                 wb_hit;
   logic                 wb_dest_mismatch;

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) queued_vec[w] = (slot_state[w] == QUEUED);
   end

   rr_arbiter #(.N(NUM_WARPS), .IW(WARP_ID_W)) u_arbiter (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (queued_vec),
      .advance   (req_ready),
      .valid     (arb_valid),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   // All decisions use the pre-edge slot state, so a writeback and a reissue to one warp never overlap.
   assign issue_ready      = (slot_state[issue_warp_id] == IDLE);
   assign accept           = issue_valid && issue_ready;
   assign grant_fire       = arb_valid && req_ready;
   assign wb_hit           = wb_valid && (slot_state[wb_warp_id] == INFLIGHT);
   assign wb_dest_mismatch = wb_hit && (wb_reg_idx != slot_dest[wb_warp_id]);

   assign req_valid    = arb_valid;
   assign req_warp_id  = arb_valid ? arb_idx : '0;
   assign req_dest_reg = arb_valid ? slot_dest[arb_idx] : '0;
   assign req_src_a    = arb_valid ? slot_a[arb_idx] : '0;
   assign req_src_b    = arb_valid ? slot_b[arb_idx] : '0;
   assign req_src_c    = arb_valid ? slot_c[arb_idx] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int w = 0; w < NUM_WARPS; w++) slot_state[w] <= IDLE;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            case (slot_state[w])
               IDLE:     if (accept && issue_warp_id == warp_id_t'(w)) slot_state[w] <= QUEUED;
               QUEUED:   if (grant_fire && arb_grant[w]) slot_state[w] <= INFLIGHT;
               INFLIGHT: if (wb_valid && wb_warp_id == warp_id_t'(w)) slot_state[w] <= IDLE;
               default:  slot_state[w] <= IDLE;
            endcase
         end
      end
   end

   // Payload is only observed while its slot is non-IDLE, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         slot_dest[issue_warp_id] <= issue_dest_reg;
         slot_a[issue_warp_id]    <= issue_src_a;
         slot_b[issue_warp_id]    <= issue_src_b;
         slot_c[issue_warp_id]    <= issue_src_c;
      end
   end

   always_comb begin
      reg_pending = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         if (slot_state[w] != IDLE) reg_pending[w*NUM_REGS + int'(slot_dest[w])] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_we        <= 1'b0;
         rf_warp_id   <= '0;
         rf_reg_idx   <= '0;
         rf_data      <= '0;
         warp_wake    <= '0;
         err_spurious <= 1'b0;
      end else begin
         rf_we     <= wb_hit;
         warp_wake <= '0;
         if (wb_hit) begin
            rf_warp_id            <= wb_warp_id;
            rf_reg_idx            <= wb_reg_idx;
            rf_data               <= wb_data;
            warp_wake[wb_warp_id] <= 1'b1;
         end
         if (wb_valid && (!wb_hit || wb_dest_mismatch)) err_spurious <= 1'b1;
      end
   end

endmodule
